// File: rtl/fdiv.sv
// fdiv: divides the board clock down to an OUT_HZ, 50 % duty square wave.
// Ports: clk_50mHz (in clock), rst (async active-high reset), clk_1Hz (divided clock, flop output).
module fdiv #(
    parameter int CLK_HZ = 50_000_000,
    parameter int OUT_HZ = 1
) (
    input  logic clk_50mHz,
    input  logic rst,
    output logic clk_1Hz
);

    // Input cycles per output half-period (truncated, so output runs slightly fast).
    localparam int HALF = (OUT_HZ > 0) ? CLK_HZ / (2 * OUT_HZ) : 0;
    localparam int CW   = (HALF <= 2) ? 1 : $clog2(HALF);
    localparam logic [CW-1:0] LAST = CW'((HALF > 0) ? HALF - 1 : 0);

    if (CLK_HZ <= 0 || OUT_HZ <= 0) begin : g_bad_hz
        $error("fdiv: CLK_HZ and OUT_HZ must both be positive");
    end

    if (HALF < 1) begin : g_bad_ratio
        $error("fdiv: OUT_HZ exceeds CLK_HZ/2, half-period would be zero");
    end

    logic [CW-1:0] cnt_q, cnt_d;
    logic          q_q, q_d;

    // Exact full-width compare keeps the counter inside 0..HALF-1.
    always_comb begin
        cnt_d = cnt_q + CW'(1);
        q_d   = q_q;
        if (cnt_q == LAST) begin
            cnt_d = '0;
            q_d   = ~q_q;
        end
    end

    always_ff @(posedge clk_50mHz or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            q_q   <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            q_q   <= q_d;
        end
    end

    assign clk_1Hz = q_q;

endmodule

// File: tb/tb_fdiv.sv
// tb_fdiv: table-driven check of fdiv at HALF=5, HALF=1 and truncated HALF=3,
// including long reset hold and asynchronous mid-period reset.
module tb_fdiv;

    logic clk;
    logic rst;
    logic o5, o1, o3;

    int n_run  = 0;
    int n_fail = 0;

    fdiv #(.CLK_HZ(10), .OUT_HZ(1)) u5 (.clk_50mHz(clk), .rst(rst), .clk_1Hz(o5));
    fdiv #(.CLK_HZ(2),  .OUT_HZ(1)) u1 (.clk_50mHz(clk), .rst(rst), .clk_1Hz(o1));
    fdiv #(.CLK_HZ(7),  .OUT_HZ(1)) u3 (.clk_50mHz(clk), .rst(rst), .clk_1Hz(o3));

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Expected state after the k-th rising edge following reset release.
    typedef struct {
        logic       q5;
        logic [2:0] c5;
        logic       q1;
        logic       q3;
    } vec_t;

    vec_t tbl [16];

    function automatic logic [5:0] pack(vec_t v);
        return {v.q5, v.c5, v.q1, v.q3};
    endfunction

    function automatic logic [5:0] actual();
        return {o5, u5.cnt_q, o1, o3};
    endfunction

    task automatic chk(input string nm, input logic [5:0] act, input logic [5:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b ({q5,cnt5,q1,q3})", nm, act, exp);
        end
    endtask

    task automatic run_table(input string tag, input int rows);
        for (int i = 0; i < rows; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("%s edge %0d", tag, i + 1), actual(), pack(tbl[i]));
        end
    endtask

    initial begin
        //         q5   c5     q1    q3
        tbl[0]  = '{1'b0, 3'd1, 1'b1, 1'b0};
        tbl[1]  = '{1'b0, 3'd2, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 3'd3, 1'b1, 1'b1};
        tbl[3]  = '{1'b0, 3'd4, 1'b0, 1'b1};
        tbl[4]  = '{1'b1, 3'd0, 1'b1, 1'b1};
        tbl[5]  = '{1'b1, 3'd1, 1'b0, 1'b0};
        tbl[6]  = '{1'b1, 3'd2, 1'b1, 1'b0};
        tbl[7]  = '{1'b1, 3'd3, 1'b0, 1'b0};
        tbl[8]  = '{1'b1, 3'd4, 1'b1, 1'b1};
        tbl[9]  = '{1'b0, 3'd0, 1'b0, 1'b1};
        tbl[10] = '{1'b0, 3'd1, 1'b1, 1'b1};
        tbl[11] = '{1'b0, 3'd2, 1'b0, 1'b0};
        tbl[12] = '{1'b0, 3'd3, 1'b1, 1'b0};
        tbl[13] = '{1'b0, 3'd4, 1'b0, 1'b0};
        tbl[14] = '{1'b1, 3'd0, 1'b1, 1'b1};
        tbl[15] = '{1'b1, 3'd1, 1'b0, 1'b1};

        rst = 1'b1;
        #1;
        chk("reset state", actual(), 6'b000000);

        // Long reset hold: everything stays at zero.
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("reset hold %0d", i), actual(), 6'b000000);
        end

        @(negedge clk);
        rst = 1'b0;
        run_table("pass1", 16);

        // Re-reset, then stop after edge 6 (q5=1, cnt5=1).
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("re-reset immediate", actual(), 6'b000000);
        @(negedge clk);
        rst = 1'b0;
        run_table("pre-pulse", 6);

        // Asynchronous reset with no clock edge in between.
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("async reset mid-period", actual(), 6'b000000);
        @(posedge clk);
        #1;
        chk("held through edge", actual(), 6'b000000);
        @(negedge clk);
        rst = 1'b0;
        run_table("post-pulse", 16);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
